// File: rtl/mos65xx_bus_ctrl_if.sv
// Signal bundle joining the 65xx soft core, the bus controller and the Atari system bus.
// The controller takes the slave view; whatever drives the core/bus side takes the master view.
interface mos65xx_bus_ctrl_if #(
  parameter int ADDR_W = 13
);
  logic [15:0]       cpu_A;
  logic              cpu_RW_n;
  logic [7:0]        cpu_Dout;
  logic [7:0]        cpu_Din;
  logic              cpu_EN;
  logic              cpu_RES_n;
  logic              cpu_RDY;
  logic              cpu_IRQ_n;
  logic              cpu_NMI_n;
  logic [ADDR_W-1:0] A;
  logic              R_W_n;
  logic [7:0]        Dout;
  logic [7:0]        Din;
  logic              WE;
  logic              HSYNC_STB;
  logic              EXT_RDY;
  logic              IRQ_n;
  logic              NMI_n;

  modport slave (
    input  cpu_A, cpu_RW_n, cpu_Dout, Din, HSYNC_STB, EXT_RDY, IRQ_n, NMI_n,
    output cpu_Din, cpu_EN, cpu_RES_n, cpu_RDY, cpu_IRQ_n, cpu_NMI_n,
           A, R_W_n, Dout, WE
  );

  modport master (
    output cpu_A, cpu_RW_n, cpu_Dout, Din, HSYNC_STB, EXT_RDY, IRQ_n, NMI_n,
    input  cpu_Din, cpu_EN, cpu_RES_n, cpu_RDY, cpu_IRQ_n, cpu_NMI_n,
           A, R_W_n, Dout, WE
  );
endinterface

// File: rtl/mos65xx_bus_ctrl.sv
// Bus controller between a clock-enable style 65xx core and the Atari system bus:
// CPU enable divider, reset stretcher, WSYNC halt driving RDY, interrupt synchronisers.
module mos65xx_bus_ctrl #(
  parameter int          ADDR_W    = 13,
  parameter int          DIV       = 3,
  parameter int          RST_CYC   = 8,
  parameter logic [15:0] HALT_ADDR = 16'h0002,
  parameter logic [15:0] HALT_MASK = 16'h1080,
  parameter bit          IRQ_EN    = 1'b0,
  parameter bit          NMI_EN    = 1'b0,
  parameter bit          DIN_REG   = 1'b1
) (
  input  logic                CLK,
  input  logic                RES_n,
  mos65xx_bus_ctrl_if.slave   bus
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic [3:0] C_DIV_LAST = 4'(DIV - 1);
  localparam logic [3:0] C_DIN_CAP  = 4'((DIV >= 2) ? (DIV - 2) : 0);
  localparam logic [7:0] C_RST_LAST = 8'(RST_CYC - 1);

  logic [3:0] r_divCnt;
  logic       r_en;
  logic       r_resN;
  logic [7:0] r_stretchCnt;
  logic [7:0] r_din;
  state_t     r_state;
  logic       r_rdy;
  logic       r_extRdyQ;
  logic [1:0] r_irqSync;
  logic [1:0] r_nmiSync;

  logic       w_we;
  logic       w_haltHit;
  state_t     w_nextState;

  // DIN_REG needs a count == DIV-2 slot, which DIV=1 does not have.
  always_ff @(posedge CLK) begin
    assert (!(DIN_REG && (DIV < 2)) && (DIV >= 1) && (DIV <= 15) &&
            (RST_CYC >= 1) && (RST_CYC <= 255))
      else $error("mos65xx_bus_ctrl: illegal parameters DIV=%0d RST_CYC=%0d DIN_REG=%0d",
                  DIV, RST_CYC, DIN_REG);
  end

  always_ff @(posedge CLK) begin
    if (!RES_n) begin
      r_divCnt     <= '0;
      r_en         <= 1'b0;
      r_resN       <= 1'b0;
      r_stretchCnt <= '0;
      r_din        <= 8'h00;
    end else begin
      r_en     <= (r_divCnt == C_DIV_LAST);
      r_divCnt <= (r_divCnt == C_DIV_LAST) ? 4'd0 : r_divCnt + 4'd1;
      if (!r_resN && r_en) begin
        if (r_stretchCnt == C_RST_LAST) begin
          r_resN <= 1'b1;
        end else begin
          r_stretchCnt <= r_stretchCnt + 8'd1;
        end
      end
      if (r_divCnt == C_DIN_CAP) begin
        r_din <= bus.Din;
      end
    end
  end

  assign w_we      = r_en & ~bus.cpu_RW_n & r_resN;
  assign w_haltHit = ((bus.cpu_A & HALT_MASK) == (HALT_ADDR & HALT_MASK));

  // A halting write outranks a coincident HSYNC strobe.
  always_comb begin
    w_nextState = r_state;
    if (w_we && w_haltHit) begin
      w_nextState = HALTED;
    end else if (bus.HSYNC_STB) begin
      w_nextState = RUN;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RES_n) begin
      r_state   <= RUN;
      r_rdy     <= 1'b1;
      r_extRdyQ <= 1'b1;
    end else begin
      r_state   <= w_nextState;
      r_extRdyQ <= bus.EXT_RDY;
      r_rdy     <= (w_nextState != HALTED) && r_extRdyQ;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RES_n) begin
      r_irqSync <= 2'b11;
      r_nmiSync <= 2'b11;
    end else begin
      r_irqSync <= {r_irqSync[0], bus.IRQ_n};
      r_nmiSync <= {r_nmiSync[0], bus.NMI_n};
    end
  end

  // The bus is held in read while the core sits in reset.
  assign bus.A         = bus.cpu_A[ADDR_W-1:0];
  assign bus.Dout      = bus.cpu_Dout;
  assign bus.R_W_n     = bus.cpu_RW_n | ~r_resN;
  assign bus.WE        = w_we;
  assign bus.cpu_EN    = r_en;
  assign bus.cpu_RES_n = r_resN;
  assign bus.cpu_RDY   = r_rdy;
  assign bus.cpu_Din   = DIN_REG ? r_din : bus.Din;
  assign bus.cpu_IRQ_n = IRQ_EN ? r_irqSync[1] : 1'b1;
  assign bus.cpu_NMI_n = NMI_EN ? r_nmiSync[1] : 1'b1;

endmodule

// File: tb/tb_mos65xx_bus_ctrl.sv
// Self-checking bench: two controller configurations share one stimulus stream and are
// compared every cycle against a cycle-count based reference model.
module tb_mos65xx_bus_ctrl;

  logic        CLK = 1'b0;
  logic        RES_n;
  logic [15:0] sA;
  logic        sRW;
  logic [7:0]  sDout;
  logic [7:0]  sDin;
  logic        sHsync;
  logic        sExt;
  logic        sIrq;
  logic        sNmi;

  int nAssert = 0;
  int nFail   = 0;

  always #5 CLK = ~CLK;

  mos65xx_bus_ctrl_if #(.ADDR_W(13)) bus0 ();
  mos65xx_bus_ctrl_if #(.ADDR_W(16)) bus1 ();

  assign bus0.cpu_A = sA;    assign bus1.cpu_A = sA;
  assign bus0.cpu_RW_n = sRW;  assign bus1.cpu_RW_n = sRW;
  assign bus0.cpu_Dout = sDout; assign bus1.cpu_Dout = sDout;
  assign bus0.Din = sDin;    assign bus1.Din = sDin;
  assign bus0.HSYNC_STB = sHsync; assign bus1.HSYNC_STB = sHsync;
  assign bus0.EXT_RDY = sExt;  assign bus1.EXT_RDY = sExt;
  assign bus0.IRQ_n = sIrq;   assign bus1.IRQ_n = sIrq;
  assign bus0.NMI_n = sNmi;   assign bus1.NMI_n = sNmi;

  mos65xx_bus_ctrl #(
    .ADDR_W(13), .DIV(3), .RST_CYC(8), .HALT_ADDR(16'h0002), .HALT_MASK(16'h1080),
    .IRQ_EN(1'b0), .NMI_EN(1'b0), .DIN_REG(1'b1)
  ) dut0 (
    .CLK(CLK), .RES_n(RES_n), .bus(bus0)
  );

  mos65xx_bus_ctrl #(
    .ADDR_W(16), .DIV(3), .RST_CYC(3), .HALT_ADDR(16'h0002), .HALT_MASK(16'h103F),
    .IRQ_EN(1'b1), .NMI_EN(1'b1), .DIN_REG(1'b0)
  ) dut1 (
    .CLK(CLK), .RES_n(RES_n), .bus(bus1)
  );

  // Model state: k = CLK edges since reset was last sampled low.
  int       k = 0;
  bit       mValid = 1'b0;
  bit [1:0] mHalted;
  bit [1:0] mRdy;
  bit       mExtQ;
  bit [7:0] mDin0;
  bit [1:0] mIrq;
  bit [1:0] mNmi;

  function automatic int rstCyc(input int i);
    return (i == 0) ? 8 : 3;
  endfunction

  function automatic bit expEn();
    return (k >= 1) && (k % 3 == 0);
  endfunction

  function automatic bit expResN(input int i);
    return k >= (3 * rstCyc(i) + 1);
  endfunction

  function automatic bit expWe(input int i);
    return expEn() && !sRW && expResN(i);
  endfunction

  function automatic bit hit(input int i);
    logic [15:0] m;
    m = (i == 0) ? 16'h1080 : 16'h103F;
    return (sA & m) == (16'h0002 & m);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model on each edge, then compare both DUTs mid-cycle.
  always @(posedge CLK) begin
    bit nh;
    if (!RES_n) begin
      k       = 0;
      mValid  = 1'b1;
      mHalted = 2'b00;
      mRdy    = 2'b11;
      mExtQ   = 1'b1;
      mDin0   = 8'h00;
      mIrq    = 2'b11;
      mNmi    = 2'b11;
    end else if (mValid) begin
      for (int i = 0; i < 2; i++) begin
        nh = (expWe(i) && hit(i)) ? 1'b1 : (sHsync ? 1'b0 : mHalted[i]);
        mRdy[i]    = !nh && mExtQ;
        mHalted[i] = nh;
      end
      mExtQ = sExt;
      if (k % 3 == 1) mDin0 = sDin;
      mIrq = {mIrq[0], sIrq};
      mNmi = {mNmi[0], sNmi};
      if (k < 1000000) k++;
    end
    #2;
    if (mValid) begin
      checkOutput("d0_cpu_EN",    32'(bus0.cpu_EN),    32'(expEn()));
      checkOutput("d0_cpu_RES_n", 32'(bus0.cpu_RES_n), 32'(expResN(0)));
      checkOutput("d0_cpu_RDY",   32'(bus0.cpu_RDY),   32'(mRdy[0]));
      checkOutput("d0_cpu_IRQ_n", 32'(bus0.cpu_IRQ_n), 32'(1));
      checkOutput("d0_cpu_NMI_n", 32'(bus0.cpu_NMI_n), 32'(1));
      checkOutput("d0_A",         32'(bus0.A),         32'(sA[12:0]));
      checkOutput("d0_R_W_n",     32'(bus0.R_W_n),     32'(sRW | !expResN(0)));
      checkOutput("d0_Dout",      32'(bus0.Dout),      32'(sDout));
      checkOutput("d0_WE",        32'(bus0.WE),        32'(expWe(0)));
      checkOutput("d0_cpu_Din",   32'(bus0.cpu_Din),   32'(mDin0));
      checkOutput("d1_cpu_EN",    32'(bus1.cpu_EN),    32'(expEn()));
      checkOutput("d1_cpu_RES_n", 32'(bus1.cpu_RES_n), 32'(expResN(1)));
      checkOutput("d1_cpu_RDY",   32'(bus1.cpu_RDY),   32'(mRdy[1]));
      checkOutput("d1_cpu_IRQ_n", 32'(bus1.cpu_IRQ_n), 32'(mIrq[1]));
      checkOutput("d1_cpu_NMI_n", 32'(bus1.cpu_NMI_n), 32'(mNmi[1]));
      checkOutput("d1_A",         32'(bus1.A),         32'(sA));
      checkOutput("d1_R_W_n",     32'(bus1.R_W_n),     32'(sRW | !expResN(1)));
      checkOutput("d1_Dout",      32'(bus1.Dout),      32'(sDout));
      checkOutput("d1_WE",        32'(bus1.WE),        32'(expWe(1)));
      checkOutput("d1_cpu_Din",   32'(bus1.cpu_Din),   32'(sDin));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #3;
  endtask

  task automatic alignTo(input int phase);
    int guard = 0;
    while ((k % 3 != phase) && guard < 6) begin
      tick();
      guard++;
    end
  endtask

  // One CPU write cycle; optionally lands an HSYNC strobe on the same CLK as WE.
  task automatic cpuWrite(input logic [15:0] a, input logic [7:0] d, input bit withHsync);
    alignTo(1);
    sA = a; sDout = d; sRW = 1'b0;
    tick();
    tick();
    checkOutput("pin_we_high", 32'(bus0.WE), 32'(1));
    checkOutput("pin_we_addr", 32'(bus0.A), 32'(a[12:0]));
    checkOutput("pin_we_data", 32'(bus0.Dout), 32'(d));
    if (withHsync) sHsync = 1'b1;
    tick();
    checkOutput("pin_we_oneclk", 32'(bus0.WE), 32'(0));
    sHsync = 1'b0;
    sRW = 1'b1;
  endtask

  task automatic hsyncPulse();
    sHsync = 1'b1;
    tick();
    sHsync = 1'b0;
  endtask

  task automatic applyStimulus();
    case ($urandom_range(0, 4))
      0:       sA = 16'h0002;
      1:       sA = 16'h0003;
      2:       sA = 16'h0083;
      3:       sA = 16'h1002;
      default: sA = 16'($urandom);
    endcase
    sRW    = ($urandom_range(0, 3) != 0);
    sDout  = 8'($urandom);
    sDin   = 8'($urandom);
    sHsync = ($urandom_range(0, 15) == 0);
    sExt   = ($urandom_range(0, 7) != 0);
    sIrq   = ($urandom_range(0, 5) != 0);
    sNmi   = ($urandom_range(0, 5) != 0);
    RES_n  = ($urandom_range(0, 399) != 0);
  endtask

  initial begin
    RES_n = 1'b0; sA = 16'h0000; sRW = 1'b1; sDout = 8'h00; sDin = 8'h00;
    sHsync = 1'b0; sExt = 1'b1; sIrq = 1'b1; sNmi = 1'b1;
    tick();
    tick();
    checkOutput("pin_rst_resn", 32'(bus0.cpu_RES_n), 32'(0));
    checkOutput("pin_rst_en",   32'(bus0.cpu_EN),    32'(0));
    checkOutput("pin_rst_rdy",  32'(bus0.cpu_RDY),   32'(1));
    checkOutput("pin_rst_din",  32'(bus0.cpu_Din),   32'(8'h00));
    checkOutput("pin_rst_irq",  32'(bus1.cpu_IRQ_n), 32'(1));

    // Release reset with a write pending: WE must stay off through the stretch.
    RES_n = 1'b1; sA = 16'h1002; sRW = 1'b0; sDout = 8'h33;
    for (int i = 1; i <= 25; i++) begin
      tick();
      if (i == 24) begin
        checkOutput("pin_stretch_en24",   32'(bus0.cpu_EN),    32'(1));
        checkOutput("pin_stretch_resn24", 32'(bus0.cpu_RES_n), 32'(0));
        checkOutput("pin_stretch_we24",   32'(bus0.WE),        32'(0));
        checkOutput("pin_stretch_rw24",   32'(bus0.R_W_n),     32'(1));
      end
      if (i == 25) checkOutput("pin_stretch_resn25", 32'(bus0.cpu_RES_n), 32'(1));
    end
    sRW = 1'b1;

    cpuWrite(16'h0002, 8'h5A, 1'b0);
    checkOutput("pin_halt_rdy0", 32'(bus0.cpu_RDY), 32'(0));
    repeat (100) tick();
    checkOutput("pin_halt_hold", 32'(bus0.cpu_RDY), 32'(0));
    hsyncPulse();
    checkOutput("pin_hsync_release", 32'(bus0.cpu_RDY), 32'(1));

    cpuWrite(16'h0083, 8'h01, 1'b0);
    checkOutput("pin_nohalt_0083", 32'(bus0.cpu_RDY), 32'(1));
    cpuWrite(16'h0003, 8'h02, 1'b0);
    checkOutput("pin_nohalt_0003_d1", 32'(bus1.cpu_RDY), 32'(1));
    hsyncPulse();

    cpuWrite(16'h0002, 8'hC3, 1'b1);
    checkOutput("pin_sameclk_rdy", 32'(bus0.cpu_RDY), 32'(0));
    repeat (5) tick();
    checkOutput("pin_sameclk_hold", 32'(bus0.cpu_RDY), 32'(0));
    hsyncPulse();
    checkOutput("pin_sameclk_release", 32'(bus0.cpu_RDY), 32'(1));
    hsyncPulse();
    tick();
    checkOutput("pin_lone_hsync", 32'(bus0.cpu_RDY), 32'(1));

    alignTo(1);
    sDin = 8'hA7;
    tick();
    sDin = 8'h11;
    tick();
    checkOutput("pin_din_en",   32'(bus0.cpu_EN),  32'(1));
    checkOutput("pin_din_reg",  32'(bus0.cpu_Din), 32'(8'hA7));
    checkOutput("pin_din_comb", 32'(bus1.cpu_Din), 32'(8'h11));

    sA = 16'hF123;
    #1;
    checkOutput("pin_addr16", 32'(bus1.A), 32'(16'hF123));
    checkOutput("pin_addr13", 32'(bus0.A), 32'(13'h1123));

    sIrq = 1'b0;
    tick();
    checkOutput("pin_irq_1clk", 32'(bus1.cpu_IRQ_n), 32'(1));
    tick();
    checkOutput("pin_irq_2clk", 32'(bus1.cpu_IRQ_n), 32'(0));
    checkOutput("pin_irq_off",  32'(bus0.cpu_IRQ_n), 32'(1));
    sIrq = 1'b1;
    tick();
    tick();

    sExt = 1'b0;
    tick();
    checkOutput("pin_ext_1clk", 32'(bus0.cpu_RDY), 32'(1));
    tick();
    checkOutput("pin_ext_2clk", 32'(bus0.cpu_RDY), 32'(0));
    sExt = 1'b1;
    tick();
    tick();
    checkOutput("pin_ext_back", 32'(bus0.cpu_RDY), 32'(1));

    cpuWrite(16'h0002, 8'h77, 1'b0);
    sExt = 1'b0;
    tick();
    tick();
    checkOutput("pin_prerst_rdy", 32'(bus0.cpu_RDY), 32'(0));
    RES_n = 1'b0;
    tick();
    checkOutput("pin_hrst_rdy",  32'(bus0.cpu_RDY),   32'(1));
    checkOutput("pin_hrst_resn", 32'(bus0.cpu_RES_n), 32'(0));
    checkOutput("pin_hrst_din",  32'(bus0.cpu_Din),   32'(8'h00));
    checkOutput("pin_hrst_en",   32'(bus0.cpu_EN),    32'(0));
    sExt = 1'b1;
    tick();
    RES_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
